fetch_rd_arbiter: RTL
=====================

// Module: fetch_rd_arbiter
// PURPOSE
//  Shares the single read port (port B) of one ram_block_sdp data RAM among NREQ fetch requesters.
//  Each requester drives a vld/rdy address channel and receives a vld/rdy data channel.
//  The block issues at most one RAM read per cycle, round-robin, and routes the 1-cycle-latency data back to the issuer.
//  It holds the data under backpressure and sustains 1 read/cycle when consumers are ready.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  A_S    8   RAM address width
//  D_S    32  RAM data width
// PORTS
//  clk       in   1          clock
//  rst       in   1          reset, synchronous, active-high
//  req_vld   in   NREQ       per-requester address valid
//  req_addr  in   NREQ*A_S   packed addresses; requester i uses [i*A_S +: A_S]
//  req_rdy   out  NREQ       per-requester address accepted (one-hot or zero)
//  rsp_vld   out  NREQ       per-requester read data valid (one-hot or zero)
//  rsp_data  out  D_S        read data, shared bus, meaningful only where rsp_vld set
//  rsp_rdy   in   NREQ       per-requester data ready
//  ram_reb   out  1          RAM port-B read enable
//  ram_addr  out  A_S        RAM port-B address
//  ram_dout  in   D_S        RAM port-B data, valid the cycle after ram_reb
// BEHAVIOUR
//  Reset values:
//   - req_rdy=0, rsp_vld=0, ram_reb=0, pending=0, rr_ptr=0.
//   - hold register undefined.
//  Issue:
//   - can_issue = ~pending | (rsp_vld[owner] & rsp_rdy[owner]).
//   - gnt = round-robin pick over req_vld, starting at rr_ptr.
//   - req_rdy = gnt & {NREQ{can_issue}}; req_rdy is combinational from req_vld and rsp_rdy.
//   - ram_reb = |req_rdy.
//   - ram_addr = addr of the granted requester; 0 when idle.
//   - On issue: rr_ptr <= gnt_idx+1 (mod NREQ); owner <= gnt_idx; pending <= 1; first <= 1.
//   - No issue: rr_ptr holds.
//  Response:
//   - Latency is exactly 1 cycle from the accept edge to rsp_vld[owner]=1.
//   - Cycle after issue (first=1): rsp_data = ram_dout; hold <= ram_dout.
//   - Later cycles (first=0): rsp_data = hold.
//   - rsp_vld[owner] = pending; all other bits are 0.
//   - Accept (rsp_vld & rsp_rdy) with no new issue: pending <= 0.
//   - Accept plus new issue in the same cycle: pending stays 1 and owner switches; this is back-to-back, with no bubble.
//   - rsp_rdy of a non-owner requester is ignored.
//  Boundaries:
//   - Single requester continuously valid and its rsp_rdy=1: 1 read per cycle.
//   - Owner stalls (rsp_rdy=0): no new issue, ram_reb=0, and rsp_data is stable from hold.
//   - All NREQ valid: grants rotate i, i+1, ... with no requester waiting more than NREQ issues.
//   - rr_ptr wraps from NREQ-1 to 0.
//   - Requester protocol: once req_vld=1 it holds req_vld and req_addr until req_rdy.
//     The arbiter drops no request, but it may regrant after a rotation.
//   - rst asserted mid-operation: a pending response is discarded and never presented; next cycle is the reset state.
//   - ram_reb is never asserted while a response would be overwritten unaccepted.
//  Assertions (bench-side):
//   - $onehot0(req_rdy) and $onehot0(rsp_vld).
//   - rsp_data stable while rsp_vld & ~rsp_rdy.
// STRUCTURE
//  fetch_arb_pkg:
//   - NREQ_MAX=8.
//   - typedef logic [$clog2(NREQ_MAX)-1:0] req_id_t.
//   - function rr_pick(vld, ptr) returning one-hot.
//  Sub-module rr_arbiter #(N):
//   - Ports: vld, adv, gnt (one-hot), gnt_idx, clk, rst.
//   - Owns rr_ptr; advances only on adv.
//  Top holds can_issue, address mux, owner/pending/first flags, hold register, response demux.
// TESTING
//  Environment:
//   - ram_block_sdp A_S=8, D_S=32, preloaded data[i]=32'h4000_0000+i.
//   - Sources and sinks built on tb_vldrdy_sink-style random drivers.
//  Directed scenarios:
//   1. Req0 alone, addr 8'h05, rsp_rdy0=1 -> ram_reb one cycle; next cycle rsp_vld=4'b0001, rsp_data=32'h4000_0005.
//   2. Req0..3 valid together, addrs 10..13, all rsp_rdy=1 -> grants 0,1,2,3 on consecutive cycles; data 4000_000A..D back-to-back, no bubble.
//   3. Req1 addr 8'h20, rsp_rdy1=0 for 5 cycles while req2 valid -> ram_reb=0, req_rdy=0 for 5 cycles; rsp_data holds 4000_0020; req2 issues in the accept cycle.
//   4. rr_ptr=3, req_vld=4'b1001 -> grant req3 then req0 (wrap).
//   5. rsp_vld high with rsp_rdy=0, assert rst one cycle -> next cycle rsp_vld=0, req_rdy=0, no response ever presented for that read.
//   6. Random 10k cycles: every accepted address returns data[addr] to the issuer, in issue order; all assertions hold.

Source files
------------

// File: rtl/fetch_rd_arbiter_pkg.sv
// Purpose : shared types and the round-robin pick function for the fetch read arbiter.
// Latency : n/a (types and combinational helper only).
// Backpressure: n/a.
// Contents: NREQ_MAX, req_id_t, rr_pick(vld, ptr, n) -> one-hot grant.
package fetch_arb_pkg;

    localparam int NREQ_MAX = 8;

    typedef logic [$clog2(NREQ_MAX)-1:0] req_id_t;

    // Returns a one-hot grant over the low n bits of vld, searching upward
    // from ptr and wrapping at n. ptr is always < n, so one subtraction wraps.
    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] vld,
        input req_id_t             ptr,
        input int                  n
    );
        logic [NREQ_MAX-1:0] g;
        logic                found;
        int                  idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (k < n && !found && vld[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/fetch_rd_arbiter_if.sv
// Purpose : bundle of requester address/data channels and the RAM port-B signals.
// Latency : n/a (wires only).
// Backpressure: req_rdy / rsp_rdy carry the vld/rdy handshakes.
// Modports: master = requesters + RAM side, slave = arbiter.
interface fetch_rd_arbiter_if #(
    parameter int NREQ = 4,
    parameter int A_S  = 8,
    parameter int D_S  = 32
);
    logic [NREQ-1:0]     req_vld;
    logic [NREQ*A_S-1:0] req_addr;
    logic [NREQ-1:0]     req_rdy;
    logic [NREQ-1:0]     rsp_vld;
    logic [D_S-1:0]      rsp_data;
    logic [NREQ-1:0]     rsp_rdy;
    logic                ram_reb;
    logic [A_S-1:0]      ram_addr;
    logic [D_S-1:0]      ram_dout;

    modport master (
        output req_vld, req_addr, rsp_rdy, ram_dout,
        input  req_rdy, rsp_vld, rsp_data, ram_reb, ram_addr
    );

    modport slave (
        input  req_vld, req_addr, rsp_rdy, ram_dout,
        output req_rdy, rsp_vld, rsp_data, ram_reb, ram_addr
    );
endinterface

// File: rtl/fetch_rd_arbiter_rr_arbiter.sv
// Purpose : round-robin grant over N valids; owns the rotating priority pointer.
// Latency : grant is combinational; pointer moves on the clock after adv.
// Backpressure: pointer holds whenever adv is low, so a stalled grant keeps its priority.
// Ports: clk, rst (sync, active-high), vld[N], adv, gnt[N] (one-hot or zero), gnt_idx.
module rr_arbiter
    import fetch_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] vld,
    input  logic         adv,
    output logic [N-1:0] gnt,
    output req_id_t      gnt_idx
);

    req_id_t             rr_ptr;
    logic [NREQ_MAX-1:0] vld_ext;
    logic [NREQ_MAX-1:0] pick;
    logic                unused_pick;

    always_comb begin
        vld_ext        = '0;
        vld_ext[N-1:0] = vld;
    end

    assign pick        = rr_pick(vld_ext, rr_ptr, N);
    assign gnt         = pick[N-1:0];
    // Bits above N are always zero; folded here so every bit has a reader.
    assign unused_pick = ^pick;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = req_id_t'(i);
            end
        end
    end

    // The requester just served drops to lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (adv) begin
            rr_ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_rd_arbiter.sv
// Purpose : shares one RAM read port among NREQ fetch requesters, round-robin, one read per cycle.
// Latency : read data presented to the issuer exactly 1 cycle after its address is accepted.
// Backpressure: data held in a register while the owner stalls; no new read issues until it is taken.
// Ports: clk, rst (sync, active-high), bus (slave modport: req_*, rsp_*, ram_* channels).
// NREQ must lie in 2..NREQ_MAX.
module fetch_rd_arbiter
    import fetch_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int A_S  = 8,
    parameter int D_S  = 32
) (
    input  logic              clk,
    input  logic              rst,
    fetch_rd_arbiter_if.slave bus
);

    logic [NREQ-1:0] gnt;
    req_id_t         gnt_idx;
    logic [NREQ-1:0] req_rdy_int;
    logic [NREQ-1:0] rsp_vld_int;
    logic            rsp_accept;
    logic            can_issue;
    logic            issue;

    logic            pending;
    logic            first;
    req_id_t         owner;
    logic [D_S-1:0]  hold;

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .vld     (bus.req_vld),
        .adv     (issue),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Handshakes are masked during reset: an issue in that cycle would be
    // wiped by the reset and the requester would think it had been served.
    always_comb begin
        rsp_vld_int = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_vld_int[i] = pending && (owner == req_id_t'(i)) && !rst;
        end
        rsp_accept  = |(rsp_vld_int & bus.rsp_rdy);
        // A new read may go out in the same cycle the current one is taken.
        can_issue   = !pending || rsp_accept;
        req_rdy_int = rst ? '0 : (gnt & {NREQ{can_issue}});
        issue       = |req_rdy_int;
    end

    always_comb begin
        bus.ram_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_rdy_int[i]) begin
                bus.ram_addr = bus.req_addr[i*A_S +: A_S];
            end
        end
    end

    assign bus.req_rdy  = req_rdy_int;
    assign bus.rsp_vld  = rsp_vld_int;
    assign bus.ram_reb  = issue;
    // RAM output is only valid the cycle after the read; after that use the copy.
    assign bus.rsp_data = first ? bus.ram_dout : hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            first   <= 1'b0;
            owner   <= '0;
        end else if (issue) begin
            pending <= 1'b1;
            first   <= 1'b1;
            owner   <= gnt_idx;
        end else begin
            first <= 1'b0;
            if (rsp_accept) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (first) begin
            hold <= bus.ram_dout;
        end
    end

endmodule
